sng_lfsr_multi: RTL

Multi-channel stochastic number generator (SNG) for the HDC/stochastic datapath.
- One parametrised Fibonacci LFSR drives CHANNELS magnitude comparators, producing one unipolar bitstream per channel.
- Start/busy/done framing covers a fixed-length stream.
- Per-channel ones counters allow closed-loop checks.
- Optional per-channel rotation of the LFSR state gives decorrelated streams.

---
 rtl/sng_lfsr_multi.sv | 87 ++++++++
 1 files changed

// File: rtl/sng_lfsr_multi.sv
// Multi-channel stochastic number generator: one Fibonacci LFSR feeds CHANNELS
// magnitude comparators, framed as a fixed-length stream with per-channel ones counters.
module sng_lfsr_multi #(
  parameter int               WIDTH      = 10,
  parameter int               CHANNELS   = 4,
  parameter logic [WIDTH-1:0] POLY       = 10'h240,
  parameter int               STREAM_LEN = 1023,
  parameter bit               DECORR     = 1'b1,
  parameter int               CW         = $clog2(STREAM_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             seed_in,
  input  logic [CHANNELS*WIDTH-1:0]    scalar_in,
  output logic                         busy,
  output logic                         bs_valid,
  output logic [CHANNELS-1:0]          bs,
  output logic                         done,
  output logic [CHANNELS*CW-1:0]       ones_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      st, st_nxt;
  logic [WIDTH-1:0]            lfsr;
  logic [CHANNELS*WIDTH-1:0]   scalar_q;
  logic [CW-1:0]               cyc;
  logic                        fb;
  logic [2*WIDTH-1:0]          lfsr_dbl;

  assign fb       = ^(lfsr & POLY);
  assign lfsr_dbl = {lfsr, lfsr};

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (start) st_nxt = S_RUN;
      S_RUN:   if (cyc == CW'(STREAM_LEN - 1)) st_nxt = S_DONE;
      S_DONE:  st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  assign busy     = (st != S_IDLE);
  assign bs_valid = (st == S_RUN);
  assign done     = (st == S_DONE);

  // A rotate-left by r is a WIDTH-bit window into the doubled state.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int ROT = i % WIDTH;
    logic [WIDTH-1:0] cmp;
    assign cmp   = DECORR ? lfsr_dbl[2*WIDTH-1-ROT -: WIDTH] : lfsr;
    assign bs[i] = bs_valid && (scalar_q[i*WIDTH +: WIDTH] > cmp);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st       <= S_IDLE;
      lfsr     <= '0;
      scalar_q <= '0;
      cyc      <= '0;
      ones_cnt <= '0;
    end else begin
      st <= st_nxt;
      case (st)
        S_IDLE: begin
          if (start) begin
            // A zero seed would lock the LFSR, so it is replaced by 1.
            lfsr     <= (seed_in == '0) ? WIDTH'(1) : seed_in;
            scalar_q <= scalar_in;
            cyc      <= '0;
            ones_cnt <= '0;
          end
        end
        S_RUN: begin
          lfsr <= {lfsr[WIDTH-2:0], fb};
          cyc  <= cyc + CW'(1);
          for (int i = 0; i < CHANNELS; i++)
            ones_cnt[i*CW +: CW] <= ones_cnt[i*CW +: CW] + CW'(bs[i]);
        end
        default: ;
      endcase
    end
  end

endmodule
